// File: rtl/wfunc_mult_sched.sv
// wfunc_mult_sched
// Applies a window function to an AXI-Stream of complex samples using an
// external complex multiplier with a fixed PIPE_NUM-cycle pipeline and a
// global enable. For each accepted beat the block issues a coefficient ROM
// read, lines the sample up with the 1-cycle ROM latency and drives the
// multiplier operands. A shadow shift register tracks valid/last through
// the multiplier so the products can be presented on an AXI-Stream master
// with backpressure.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   win_sel, bypass       window select / unity-coefficient bypass, latched
//                         on the first beat of each frame
//   s_tvalid/s_tready/s_tdata/s_tlast   sample input stream, {im,re}
//   coef_rd, coef_addr    ROM read strobe and address (win*N + idx)
//   coef_data             ROM read data, valid one cycle after coef_rd
//   mult_en, mult_a, mult_b, mult_z     external multiplier interface
//   m_tvalid/m_tready/m_tdata/m_tlast   product output stream, {im,re}
//   err_len               one-cycle pulse on a frame-length violation
//   frame_cnt             completed input frames (wrapping)
module wfunc_mult_sched #(
    parameter int DATA_W   = 16,
    parameter int PROD_W   = 32,
    parameter int N        = 1024,
    parameter int WIN_NUM  = 4,
    parameter int PIPE_NUM = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(WIN_NUM)-1:0]   win_sel,
    input  logic                         bypass,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [2*DATA_W-1:0]          s_tdata,
    input  logic                         s_tlast,
    output logic                         coef_rd,
    output logic [$clog2(WIN_NUM*N)-1:0] coef_addr,
    input  logic [2*DATA_W-1:0]          coef_data,
    output logic                         mult_en,
    output logic [2*DATA_W-1:0]          mult_a,
    output logic [2*DATA_W-1:0]          mult_b,
    input  logic [2*PROD_W-1:0]          mult_z,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [2*PROD_W-1:0]          m_tdata,
    output logic                         m_tlast,
    output logic                         err_len,
    output logic [15:0]                  frame_cnt
);

    localparam int WSEL_W = $clog2(WIN_NUM);
    localparam int IDX_W  = $clog2(N);
    localparam int ADDR_W = $clog2(WIN_NUM * N);

    // Unity in Q2.(DATA_W-2): re = 1 << (DATA_W-2), im = 0.
    localparam logic [2*DATA_W-1:0] COEF_UNITY = (2*DATA_W)'(1) << (DATA_W - 2);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WSEL_W-1:0]   win_q, win_d;
    logic                byp_q, byp_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                err_len_q, err_len_d;

    logic                adv;
    logic                accept;
    logic [WSEL_W-1:0]   win_eff;
    logic                byp_eff;
    logic [IDX_W-1:0]    idx_eff;
    logic                at_end;
    logic                close_beat;

    // Align stage registers (sample waiting for its coefficient)
    logic                vld_p0_q, vld_p0_d;
    logic                last_p0_q, last_p0_d;
    logic                byp_p0_q, byp_p0_d;
    logic                rd_p0_q, rd_p0_d;
    logic [2*DATA_W-1:0] samp_p0_q, samp_p0_d;
    logic [2*DATA_W-1:0] coef_p0_q, coef_p0_d;

    // Operand register plus shadow of the multiplier pipe
    logic [2*DATA_W-1:0] mult_a_q, mult_a_d;
    logic [2*DATA_W-1:0] mult_b_q, mult_b_d;
    logic [PIPE_NUM:0]   vld_sh_q, vld_sh_d;
    logic [PIPE_NUM:0]   last_sh_q, last_sh_d;

    // One advance condition moves everything: input, align, operands,
    // multiplier and shadow. A stalled output freezes the whole pipe.
    assign adv      = ~vld_sh_q[PIPE_NUM] | m_tready;
    assign accept   = s_tvalid & adv;
    assign s_tready = adv;
    assign mult_en  = adv;

    // First beat of a frame uses the live win_sel/bypass and index 0.
    assign win_eff    = (state_q == S_IDLE) ? win_sel : win_q;
    assign byp_eff    = (state_q == S_IDLE) ? bypass  : byp_q;
    assign idx_eff    = (state_q == S_IDLE) ? '0      : idx_q;
    assign at_end     = (idx_eff == IDX_W'(N - 1));
    assign close_beat = s_tlast | at_end;

    assign coef_rd   = accept;
    assign coef_addr = accept ? ADDR_W'({win_eff, idx_eff}) : '0;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        win_d       = win_q;
        byp_d       = byp_q;
        frame_cnt_d = frame_cnt_q;
        err_len_d   = 1'b0;
        if (accept) begin
            win_d = win_eff;
            byp_d = byp_eff;
            if (close_beat) begin
                // Normal end only when tlast lands exactly on index N-1;
                // short and overlong frames both close and flag an error.
                state_d     = S_IDLE;
                idx_d       = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                err_len_d   = ~(s_tlast & at_end);
            end else begin
                state_d = S_RUN;
                idx_d   = idx_eff + IDX_W'(1);
            end
        end
    end

    always_comb begin
        vld_p0_d  = vld_p0_q;
        last_p0_d = last_p0_q;
        byp_p0_d  = byp_p0_q;
        samp_p0_d = samp_p0_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        vld_sh_d  = vld_sh_q;
        last_sh_d = last_sh_q;
        // ROM data is only valid the cycle after the read, so it is captured
        // regardless of adv and reused if the pipe was stalled meanwhile.
        rd_p0_d   = coef_rd;
        coef_p0_d = rd_p0_q ? coef_data : coef_p0_q;
        if (adv) begin
            // Align stage -> operand stage
            vld_p0_d  = accept;
            last_p0_d = accept & close_beat;
            if (accept) begin
                samp_p0_d = s_tdata;
                byp_p0_d  = byp_eff;
            end
            mult_a_d = samp_p0_q;
            if (byp_p0_q) begin
                mult_b_d = COEF_UNITY;
            end else if (rd_p0_q) begin
                mult_b_d = coef_data;
            end else begin
                mult_b_d = coef_p0_q;
            end
            // Operand stage -> multiplier pipe shadow
            vld_sh_d  = {vld_sh_q[PIPE_NUM-1:0], vld_p0_q};
            last_sh_d = {last_sh_q[PIPE_NUM-1:0], last_p0_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            win_q       <= '0;
            byp_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_len_q   <= 1'b0;
            vld_p0_q    <= 1'b0;
            last_p0_q   <= 1'b0;
            byp_p0_q    <= 1'b0;
            rd_p0_q     <= 1'b0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            vld_sh_q    <= '0;
            last_sh_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            win_q       <= win_d;
            byp_q       <= byp_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
            vld_p0_q    <= vld_p0_d;
            last_p0_q   <= last_p0_d;
            byp_p0_q    <= byp_p0_d;
            rd_p0_q     <= rd_p0_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            vld_sh_q    <= vld_sh_d;
            last_sh_q   <= last_sh_d;
        end
    end

    // Pure datapath holding registers; qualified by the valid bits above.
    always_ff @(posedge clk) begin
        samp_p0_q <= samp_p0_d;
        coef_p0_q <= coef_p0_d;
    end

    // Output stage: products pass straight from the multiplier.
    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign m_tvalid  = vld_sh_q[PIPE_NUM];
    assign m_tlast   = last_sh_q[PIPE_NUM];
    assign m_tdata   = mult_z;
    assign err_len   = err_len_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_wfunc_mult_sched.sv
`timescale 1ns/1ps
module tb_wfunc_mult_sched;
    localparam int DATA_W   = 16;
    localparam int PROD_W   = 32;
    localparam int N        = 8;
    localparam int WIN_NUM  = 4;
    localparam int PIPE_NUM = 10;
    localparam int WSEL_W   = $clog2(WIN_NUM);
    localparam int ADDR_W   = $clog2(WIN_NUM * N);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [WSEL_W-1:0]     win_sel;
    logic                  bypass;
    logic                  s_tvalid;
    logic                  s_tready;
    logic [2*DATA_W-1:0]   s_tdata;
    logic                  s_tlast;
    logic                  coef_rd;
    logic [ADDR_W-1:0]     coef_addr;
    logic [2*DATA_W-1:0]   coef_data;
    logic                  mult_en;
    logic [2*DATA_W-1:0]   mult_a;
    logic [2*DATA_W-1:0]   mult_b;
    logic [2*PROD_W-1:0]   mult_z;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [2*PROD_W-1:0]   m_tdata;
    logic                  m_tlast;
    logic                  err_len;
    logic [15:0]           frame_cnt;

    always #5 clk = ~clk;

    wfunc_mult_sched #(
        .DATA_W(DATA_W), .PROD_W(PROD_W), .N(N), .WIN_NUM(WIN_NUM), .PIPE_NUM(PIPE_NUM)
    ) dut (
        .clk(clk), .rst(rst), .win_sel(win_sel), .bypass(bypass),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .coef_rd(coef_rd), .coef_addr(coef_addr), .coef_data(coef_data),
        .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_z(mult_z),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .err_len(err_len), .frame_cnt(frame_cnt)
    );

    // Coefficient contents: a fixed pseudo-random pattern per address.
    function automatic logic [2*DATA_W-1:0] rom_word(input int addr);
        int re, im;
        re = (addr * 1237 + 311) % 32768 - 16384;
        im = (addr * 733 + 97) % 32768 - 16384;
        return {im[DATA_W-1:0], re[DATA_W-1:0]};
    endfunction

    function automatic logic [2*PROD_W-1:0] cprod(input int sr, input int si, input int cr, input int ci);
        longint re, im;
        re = longint'(sr) * cr - longint'(si) * ci;
        im = longint'(sr) * ci + longint'(si) * cr;
        return {im[PROD_W-1:0], re[PROD_W-1:0]};
    endfunction

    // ROM environment: registered read; garbage on cycles without a read.
    always @(posedge clk) begin
        if (coef_rd) coef_data <= rom_word(int'(coef_addr));
        else         coef_data <= $urandom;
    end

    // Multiplier environment: PIPE_NUM enabled stages, no reset.
    logic [2*PROD_W-1:0] mpipe [PIPE_NUM];
    always @(posedge clk) begin
        if (mult_en) begin
            mpipe[0] <= cprod(int'($signed(mult_a[DATA_W-1:0])), int'($signed(mult_a[2*DATA_W-1:DATA_W])),
                              int'($signed(mult_b[DATA_W-1:0])), int'($signed(mult_b[2*DATA_W-1:DATA_W])));
            for (int i = 1; i < PIPE_NUM; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mult_z = mpipe[PIPE_NUM-1];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame position counting and expected-product queue.
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    bit          in_frame = 0;
    int          pos = 0;
    int          win_l = 0;
    bit          byp_l = 0;
    bit          err_next = 0;
    int          frames = 0;
    int          errs_seen = 0;
    int          out_cnt = 0;
    int          cyc = 0;
    int          acc_cyc = -1;
    int          val_cyc = -1;
    logic [63:0] last_out = '0;
    int          m_sr, m_si, m_cr, m_ci, m_addr;
    bit          m_close, m_err;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            in_frame = 0;
            err_next = 0;
            frames   = 0;
        end else begin
            check("err_len", 64'(err_len), 64'(err_next));
            if (err_len) errs_seen++;
            check("mult_en", 64'(mult_en), 64'(!m_tvalid || m_tready));
            check("s_tready", 64'(s_tready), 64'(!m_tvalid || m_tready));
            err_next = 0;
            if (s_tvalid && s_tready) begin
                if (!in_frame) begin
                    win_l = int'(win_sel);
                    byp_l = bypass;
                    pos = 0;
                    in_frame = 1;
                end
                m_addr = win_l * N + pos;
                check("coef_rd", 64'(coef_rd), 64'(1));
                check("coef_addr", 64'(coef_addr), 64'(m_addr));
                m_sr = int'($signed(s_tdata[DATA_W-1:0]));
                m_si = int'($signed(s_tdata[2*DATA_W-1:DATA_W]));
                if (byp_l) begin
                    m_cr = 1 << (DATA_W - 2);
                    m_ci = 0;
                end else begin
                    m_cr = (m_addr * 1237 + 311) % 32768 - 16384;
                    m_ci = (m_addr * 733 + 97) % 32768 - 16384;
                end
                m_close = s_tlast || (pos == N - 1);
                m_err = m_close && !(s_tlast && pos == N - 1);
                err_next = m_err;
                if (m_close) begin
                    in_frame = 0;
                    frames++;
                end else begin
                    pos++;
                end
                exp_q.push_back('{data: 64'(cprod(m_sr, m_si, m_cr, m_ci)), last: m_close});
                if (acc_cyc < 0) acc_cyc = cyc;
            end else begin
                check("coef_rd_idle", 64'(coef_rd), 64'(0));
            end
            if (m_tvalid && val_cyc < 0) val_cyc = cyc;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("out_extra", 64'(m_tvalid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("m_tdata", 64'(m_tdata), e.data);
                    check("m_tlast", 64'(m_tlast), 64'(e.last));
                end
                out_cnt++;
                last_out = 64'(m_tdata);
            end
        end
    end

    int rdy_mode = 0;
    int phase = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        phase++;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = ((phase % 4) == 0) || ((phase % 4) == 3);
            2: m_tready = 1'b0;
            default: m_tready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic send(input int re, input int im, input bit last);
        bit done = 0;
        int guard = 0;
        s_tvalid = 1'b1;
        s_tdata  = {DATA_W'(im), DATA_W'(re)};
        s_tlast  = last;
        while (!done) begin
            @(negedge clk);
            done = s_tready;
            tick();
            guard++;
            if (!done && guard > 200) begin
                check("send_timeout", 64'(0), 64'(1));
                done = 1;
            end
        end
    endtask

    task automatic send_rand(input bit last);
        int re, im;
        re = int'($urandom_range(40000)) - 20000;
        im = int'($urandom_range(40000)) - 20000;
        send(re, im, last);
    endtask

    task automatic drain();
        int g = 0;
        s_tvalid = 1'b0;
        while (exp_q.size() != 0 && g < 500) begin
            tick();
            g++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    logic [63:0] exp_byp;

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        win_sel = '0; bypass = 1'b0; m_tready = 1'b1; rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_m_tlast", 64'(m_tlast), 64'(0));
        check("rst_err_len", 64'(err_len), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("rst_coef_rd", 64'(coef_rd), 64'(0));
        check("rst_coef_addr", 64'(coef_addr), 64'(0));
        check("rst_mult_a", 64'(mult_a), 64'(0));
        check("rst_mult_b", 64'(mult_b), 64'(0));
        check("rst_mult_en", 64'(mult_en), 64'(1));
        rst = 1'b0;
        tick();

        // Full frame, window 2, no backpressure
        acc_cyc = -1; val_cyc = -1; out_cnt = 0;
        win_sel = 2'd2;
        for (int i = 0; i < N; i++) send_rand(i == N - 1);
        drain();
        check("t1_latency", 64'(val_cyc - acc_cyc - 1), 64'(PIPE_NUM + 1));
        check("t1_count", 64'(out_cnt), 64'(N));
        check("t1_frame_cnt", 64'(frame_cnt), 64'(1));
        check("t1_errs", 64'(errs_seen), 64'(0));

        // Full frame with m_tready 1,0,0,1; win_sel change mid-frame ignored
        rdy_mode = 1; out_cnt = 0;
        win_sel = 2'd1;
        for (int i = 0; i < N; i++) begin
            if (i == 3) win_sel = 2'd3;
            send_rand(i == N - 1);
        end
        drain();
        rdy_mode = 0;
        check("t2_count", 64'(out_cnt), 64'(N));
        check("t2_frame_cnt", 64'(frame_cnt), 64'(2));

        // Short frame (tlast on beat 5) followed by a fresh full frame
        out_cnt = 0;
        win_sel = 2'd0;
        for (int i = 0; i < 5; i++) send_rand(i == 4);
        win_sel = 2'd3;
        for (int i = 0; i < N; i++) send_rand(i == N - 1);
        drain();
        check("t3_count", 64'(out_cnt), 64'(5 + N));
        check("t3_errs", 64'(errs_seen), 64'(1));
        check("t3_frame_cnt", 64'(frame_cnt), 64'(4));

        // Overlong frame: 10 beats without tlast, then close the next frame
        out_cnt = 0;
        win_sel = 2'd1;
        for (int i = 0; i < 10; i++) send_rand(1'b0);
        check("t4_frame_cnt_mid", 64'(frame_cnt), 64'(5));
        for (int i = 0; i < 6; i++) send_rand(i == 5);
        drain();
        check("t4_count", 64'(out_cnt), 64'(16));
        check("t4_errs", 64'(errs_seen), 64'(2));
        check("t4_frame_cnt", 64'(frame_cnt), 64'(6));

        // Bypass: unity coefficient
        bypass = 1'b1;
        win_sel = 2'd2;
        send(100, -50, 1'b1);
        s_tvalid = 1'b0;
        tick();
        check("t5_mult_a", 64'(mult_a), 64'({DATA_W'(-50), DATA_W'(100)}));
        check("t5_mult_b", 64'(mult_b), 64'({DATA_W'(0), DATA_W'(16384)}));
        drain();
        bypass = 1'b0;
        exp_byp = {32'(-819200), 32'(1638400)};
        check("t5_product", last_out, exp_byp);
        check("t5_errs", 64'(errs_seen), 64'(3));

        // Reset with products stalled in flight
        rdy_mode = 2; m_tready = 1'b0;
        win_sel = 2'd1;
        for (int i = 0; i < 5; i++) send_rand(1'b0);
        s_tvalid = 1'b0;
        repeat (8) tick();
        check("t6_stalled_valid", 64'(m_tvalid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("t6_rst_m_tlast", 64'(m_tlast), 64'(0));
        check("t6_rst_frame_cnt", 64'(frame_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0; m_tready = 1'b1;
        tick();
        out_cnt = 0;
        for (int i = 0; i < N; i++) send_rand(i == N - 1);
        drain();
        check("t6_count", 64'(out_cnt), 64'(N));
        check("t6_frame_cnt", 64'(frame_cnt), 64'(1));

        // Random frames, random backpressure, random gaps
        rdy_mode = 3;
        for (int f = 0; f < 5; f++) begin
            int len;
            len = int'($urandom_range(3, 10));
            win_sel = WSEL_W'($urandom_range(WIN_NUM - 1));
            bypass = 1'($urandom_range(1));
            for (int i = 0; i < len; i++) begin
                send_rand(i == len - 1);
                if ($urandom_range(3) == 0) begin
                    s_tvalid = 1'b0;
                    tick();
                end
            end
        end
        drain();
        rdy_mode = 0;
        tick();
        check("t7_frame_cnt", 64'(frame_cnt), 64'(frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
